// File: rtl/mem2axi_if.sv
// AXI4 bus bundle (AXI_BUS) with Master and Slave modports, used by the mem2axi bridge.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 10,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

    logic [AXI_ID_WIDTH-1:0]   aw_id;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      aw_lock;
    logic [3:0]                aw_cache;
    logic [2:0]                aw_prot;
    logic [3:0]                aw_qos;
    logic [3:0]                aw_region;
    logic [5:0]                aw_atop;
    logic [AXI_USER_WIDTH-1:0] aw_user;
    logic                      aw_valid;
    logic                      aw_ready;

    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0]     w_strb;
    logic                      w_last;
    logic [AXI_USER_WIDTH-1:0] w_user;
    logic                      w_valid;
    logic                      w_ready;

    logic [AXI_ID_WIDTH-1:0]   b_id;
    logic [1:0]                b_resp;
    logic [AXI_USER_WIDTH-1:0] b_user;
    logic                      b_valid;
    logic                      b_ready;

    logic [AXI_ID_WIDTH-1:0]   ar_id;
    logic [AXI_ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      ar_lock;
    logic [3:0]                ar_cache;
    logic [2:0]                ar_prot;
    logic [3:0]                ar_qos;
    logic [3:0]                ar_region;
    logic [AXI_USER_WIDTH-1:0] ar_user;
    logic                      ar_valid;
    logic                      ar_ready;

    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic [1:0]                r_resp;
    logic                      r_last;
    logic [AXI_USER_WIDTH-1:0] r_user;
    logic                      r_valid;
    logic                      r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/mem2axi.sv
// Memory req/gnt port to AXI4 master bridge, single-beat, one transaction outstanding.
// Define MEM2AXI_ERR_EN to report SLVERR/DECERR responses on err_o.
module mem2axi #(
    parameter int unsigned             AXI_ID_WIDTH   = 10,
    parameter int unsigned             AXI_ADDR_WIDTH = 64,
    parameter int unsigned             AXI_DATA_WIDTH = 64,
    parameter int unsigned             AXI_USER_WIDTH = 10,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID         = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_i,
    output logic                        gnt_o,
    input  logic                        we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] be_i,
    input  logic [AXI_USER_WIDTH-1:0]   user_i,
    input  logic [AXI_DATA_WIDTH-1:0]   data_i,
    output logic                        rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]   rdata_o,
    output logic [AXI_USER_WIDTH-1:0]   ruser_o,
    output logic                        err_o,
    output logic [2:0]                  state_o,
    AXI_BUS.Master                      master
);
    localparam int unsigned LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0]  AXI_SIZE     = 3'(LOG_NR_BYTES);

    typedef enum logic [2:0] {IDLE = 3'd0, AR = 3'd1, R = 3'd2, AW_W = 3'd3, B = 3'd4} state_e;

    state_e                      state_q, state_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic                        load;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic [AXI_USER_WIDTH-1:0]   user_q;
    logic [AXI_DATA_WIDTH-1:0]   data_q;

    assign state_o = state_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            user_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            if (load) begin
                addr_q <= addr_i;
                be_q   <= be_i;
                user_q <= user_i;
                data_q <= data_i;
            end
        end
    end

    // Handshakes: a transfer happens on a cycle where valid && ready; valids depend only on
    // registered state, are never withdrawn before that cycle, and payloads come from registers.
    always_comb begin
        state_d          = state_q;
        aw_done_d        = aw_done_q;
        w_done_d         = w_done_q;
        load             = 1'b0;
        gnt_o            = 1'b0;
        rvalid_o         = 1'b0;
        rdata_o          = '0;
        ruser_o          = '0;
        err_o            = 1'b0;
        master.ar_valid  = 1'b0;
        master.r_ready   = 1'b0;
        master.aw_valid  = 1'b0;
        master.w_valid   = 1'b0;
        master.b_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    load    = 1'b1;
                    state_d = we_i ? AW_W : AR;
                end
            end
            AR: begin
                master.ar_valid = 1'b1;
                if (master.ar_ready) state_d = R;
            end
            R: begin
                master.r_ready = 1'b1;
                if (master.r_valid) begin
                    rvalid_o = 1'b1;
                    rdata_o  = master.r_data;
                    ruser_o  = master.r_user;
`ifdef MEM2AXI_ERR_EN
                    err_o    = master.r_resp[1];
`endif
                    state_d  = IDLE;
                end
            end
            AW_W: begin
                master.aw_valid = !aw_done_q;
                master.w_valid  = !w_done_q;
                aw_done_d       = aw_done_q | master.aw_ready;
                w_done_d        = w_done_q | master.w_ready;
                // AW and W may complete in either order; leave only once both have.
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = B;
                end
            end
            B: begin
                master.b_ready = 1'b1;
                if (master.b_valid) begin
                    rvalid_o = 1'b1;
`ifdef MEM2AXI_ERR_EN
                    err_o    = master.b_resp[1];
`endif
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign master.ar_id     = AXI_ID;
    assign master.ar_addr   = addr_q;
    assign master.ar_len    = 8'd0;
    assign master.ar_size   = AXI_SIZE;
    assign master.ar_burst  = 2'b01;
    assign master.ar_lock   = 1'b0;
    assign master.ar_cache  = 4'd0;
    assign master.ar_prot   = 3'd0;
    assign master.ar_qos    = 4'd0;
    assign master.ar_region = 4'd0;
    assign master.ar_user   = user_q;

    assign master.aw_id     = AXI_ID;
    assign master.aw_addr   = addr_q;
    assign master.aw_len    = 8'd0;
    assign master.aw_size   = AXI_SIZE;
    assign master.aw_burst  = 2'b01;
    assign master.aw_lock   = 1'b0;
    assign master.aw_cache  = 4'd0;
    assign master.aw_prot   = 3'd0;
    assign master.aw_qos    = 4'd0;
    assign master.aw_region = 4'd0;
    assign master.aw_atop   = 6'd0;
    assign master.aw_user   = user_q;

    assign master.w_data    = data_q;
    assign master.w_strb    = be_q;
    assign master.w_last    = 1'b1;
    assign master.w_user    = user_q;

    // IDs, r_last and b_user carry no information with a single outstanding single-beat transfer.
    logic unused_inputs;
    assign unused_inputs = ^{master.r_id, master.r_last, master.b_id, master.b_user,
                             master.r_resp, master.b_resp};
endmodule

// File: doc/mem2axi.md
# mem2axi

Memory-request to AXI4 master bridge: converts a simple req/gnt memory port (req, we, addr, be, data, user) into single-beat AXI4 read and write transactions on an `AXI_BUS.Master` port. It is the initiator-side counterpart of the AXI-to-SRAM slave adapter, letting a core-side or DMA-side memory port reach any AXI slave in the fabric. One transaction is outstanding at a time.

## Interface
Parameters:
- AXI_ID_WIDTH, 10, AXI ID width
- AXI_ADDR_WIDTH, 64, address width (memory and AXI side)
- AXI_DATA_WIDTH, 64, data width (memory and AXI side); power of two, >= 8
- AXI_USER_WIDTH, 10, user signal width
- AXI_ID, 0, constant ID driven on aw_id/ar_id

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  memory request valid
- gnt_o  out  1  request accepted this cycle
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AXI_ADDR_WIDTH  byte address
- be_i  in  AXI_DATA_WIDTH/8  write byte enables
- user_i  in  AXI_USER_WIDTH  request user bits
- data_i  in  AXI_DATA_WIDTH  write data
- rvalid_o  out  1  response pulse (read data or write ack)
- rdata_o  out  AXI_DATA_WIDTH  read data, valid with rvalid_o
- ruser_o  out  AXI_USER_WIDTH  r_user of read response
- err_o  out  1  error response, valid with rvalid_o
- master  AXI_BUS.Master  -  AXI4 master port

## Operation
- LOG_NR_BYTES = $clog2(AXI_DATA_WIDTH/8).
- States: IDLE, AR, R, AW_W, B.
- IDLE: gnt_o = req_i. On req_i, register we_i, addr_i, be_i, user_i, data_i; go to AW_W if we_i else AR. gnt_o = 0 in every other state.
- AR: ar_valid = 1, ar_addr = registered addr, ar_len = 0, ar_size = LOG_NR_BYTES, ar_burst = INCR (2'b01), ar_id = AXI_ID, ar_user = registered user. On ar_ready -> R.
- R: r_ready = 1. On r_valid: rvalid_o = 1, rdata_o = r_data, ruser_o = r_user -> IDLE.
- AW_W: aw_valid and w_valid asserted together; aw fields as AR; w_data/w_strb/w_user from registers, w_last = 1. Flags aw_done/w_done set on each handshake; each valid deasserts once its flag is set. When both handshakes are complete (same or different cycles) -> B; flags cleared.
- B: b_ready = 1. On b_valid: rvalid_o = 1 (rdata_o don't care) -> IDLE.
- r_id/b_id ignored (single outstanding). r_last ignored (len = 0).
- All other AXI master outputs (lock, cache, prot, qos, region, atop) driven 0.
- Address passed unmodified; no alignment or 4 KB checks.

## Timing
- Reset values: gnt_o 0 unless req_i in IDLE, rvalid_o 0, err_o 0, rdata_o 0, ruser_o 0, all AXI valids/readies 0, state IDLE, aw_done/w_done 0.
- gnt_o, rvalid_o, rdata_o, err_o are combinational from state and AXI inputs; all AXI request channel outputs are registered-state-driven (no combinational path from req_i to ar_valid/aw_valid).
- Minimum read latency: req_i granted at cycle 0, ar_valid at cycle 1, rvalid_o at cycle 2 if ar_ready at 1 and r_valid at 2.
- Minimum write latency: grant at 0, aw/w handshake at 1, rvalid_o at 2 if b_valid at 2.
- Valids never withdrawn before handshake (AXI rule); addr/data stable while valid.
- Next request can be granted in the cycle after rvalid_o (state IDLE).
- r_valid/b_valid in a non-matching state: not accepted (ready low).
- Reset mid-transaction: all outputs return to reset values immediately; in-flight AXI transaction abandoned.

## Configuration
- MEM2AXI_ERR_EN defined: err_o = r_resp[1] in R, b_resp[1] in B, qualified by rvalid_o (SLVERR/DECERR flagged).
- Not defined: err_o tied 0, r_resp/b_resp ignored.

## Test plan
- Read: req_i we_i=0 addr=0x1000 -> ar_addr=0x1000, ar_len=0, ar_size=3 (64-bit); r_data=0xDEADBEEF with r_valid -> rvalid_o=1 one cycle, rdata_o=0xDEADBEEF.
- Write, AW/W split: addr=0x2008 be=0x0F data=0x1234; aw_ready at cycle 1, w_ready at cycle 4 -> aw_valid drops at 2, w_valid held to 4, w_last=1, w_strb=0x0F; b_valid -> rvalid_o pulse.
- Backpressure: ar_ready held 0 for 5 cycles -> ar_valid and ar_addr stable, gnt_o=0 for a second req_i throughout.
- Back-to-back: two reads with zero-wait slave -> second gnt_o the cycle after first rvalid_o; throughput one read per 3 cycles.
- Error (MEM2AXI_ERR_EN): b_resp=2'b10 -> err_o=1 with rvalid_o; without macro err_o=0.
- Reset in B state: rst_ni low -> b_ready, rvalid_o 0 immediately; after release, new read completes normally.
